chacha_block_sched: RTL and testbench
=====================================

Name: chacha_block_sched

Overview:
- Controller that sequences the ChaCha20 quarter-round core (`PerformQround`-style datapath) to produce a run of keystream blocks.
- Accepts a key/nonce/start-counter/block-count command and builds the 4x4 initial state for each block.
- Pulses the core's round-init input, waits for its block-ready, then buffers the 512-bit result and presents it downstream with valid/ready.
- Sits between the AEAD top-level (cipher and Poly1305 key derivation) and the core.

Parameters:
- MAX_BLOCKS, 16, largest accepted cmd_nblocks; width of the internal blocks-left counter is $clog2(MAX_BLOCKS+1).
- CORE_TIMEOUT, 256, cycles to wait for core_blockready after init before flagging error.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- cmd_valid  in  1  command strobe.
- cmd_ready  out  1  high only in IDLE.
- cmd_key  in  8x32  key words k0..k7.
- cmd_nonce  in  3x32  nonce words n0..n2.
- cmd_ctr  in  32  first block counter.
- cmd_nblocks  in  $clog2(MAX_BLOCKS+1)  blocks to produce; 0 = no-op.
- abort  in  1  synchronous abort of the current command.
- core_init  out  1  one-cycle pulse; core loads core_matrix and restarts rounds.
- core_matrix  out  4x4x32  initial state to core (word_t [3:0][3:0]).
- core_blockready  in  1  core result valid.
- core_result  in  4x4x32  core final state (already added to initial).
- blk_valid  out  1  keystream block available.
- blk_ready  in  1  downstream accepts.
- blk_data  out  4x4x32  keystream block.
- blk_ctr  out  32  counter value used for blk_data.
- busy  out  1  state != IDLE.
- done  out  1  one-cycle pulse when the command completes normally.
- err  out  1  sticky error; cleared by rst or the next accepted command.

Behaviour:
- Reset values: cmd_ready=1, core_init=0, core_matrix=0, blk_valid=0, blk_data=0, blk_ctr=0, busy=0, done=0, err=0; FSM=IDLE.
- State layout:
  - row0 = 0x61707865, 0x3320646e, 0x79622d32, 0x6b206574.
  - row1 = k0..k3; row2 = k4..k7.
  - row3 = ctr, n0, n1, n2.
  - Index is [row][col]; the core's column rounds operate on [0..3][c].
- Key, nonce, count and counter are latched on the cmd_valid & cmd_ready handshake.
- FSM IDLE -> LOAD -> RUN -> OUT -> (LOAD | IDLE).
  - IDLE: on handshake with nblocks != 0, go to LOAD. With nblocks == 0, pulse done next cycle and stay in IDLE.
  - LOAD: one cycle. Assert core_init=1 with core_matrix valid on the same cycle; clear the watchdog; go to RUN.
  - RUN: core_matrix held stable. On core_blockready, capture core_result into blk_data, set blk_ctr=ctr and blk_valid=1 next cycle, then go to OUT. If the watchdog reaches CORE_TIMEOUT first, set err=1 and go to IDLE (no done).
  - OUT: blk_valid and blk_data are held until blk_ready.
    - On the handshake cycle: ctr<=ctr+1 (mod 2^32), left<=left-1.
    - If left==1: go to IDLE and pulse done the following cycle. Otherwise go to LOAD.
    - blk_ready while blk_valid=0 is ignored.
- Latency: block valid in the 3rd cycle after core_blockready rises? No: exactly 1 cycle after core_blockready is sampled. Minimum of 2 cycles between a blk handshake and the next core_init.
- core_blockready is ignored outside RUN.
- abort (any state except IDLE) takes priority over every other event that cycle:
  - FSM -> IDLE, blk_valid=0, core_init=0, no done, err unchanged.
- Counter wrap: if ctr is 0xFFFFFFFF after a delivered block and blocks remain, behaviour depends on CHACHA_CTR_WRAP_ERR_EN.
- rst mid-operation returns all outputs to reset values on the next edge.

Optional Feature:
- Macro: CHACHA_CTR_WRAP_ERR_EN.
- Defined: a blk handshake with ctr==0xFFFFFFFF and left>1 sets err=1 and goes to IDLE without done. The wrapped block is never requested. Matches RFC 8439's 2^32-block limit per nonce.
- Undefined: ctr wraps silently to 0 and the run continues.

Decomposition:
- Shared package chacha_pkg:
  - word_t (logic [31:0]);
  - matrix_t (word_t [3:0][3:0]);
  - the four sigma constants CHACHA_C0..C3;
  - state enum sched_state_t {IDLE, LOAD, RUN, OUT}.
- Sub-module chacha_state_build: purely combinational key/nonce/ctr -> matrix_t. Reused by the Poly1305 key-gen path.
- Watchdog counter stays inline.

Test Plan:
- RFC 8439 2.3.2 vector (key 00..1f, nonce 00000009_0000004a_00000000, ctr=1, nblocks=1, real core) -> one blk with blk_data[0][0]=0xe4e7f110, blk_ctr=1, done pulse, cmd_ready back to 1.
- Stub core (blockready 10 cycles after init), nblocks=4, ctr=7, blk_ready held low 5 cycles per block -> blk_ctr 7,8,9,10; data stable while stalled; exactly 4 core_init pulses; one done.
- nblocks=0 -> no core_init, done one cycle later, busy never high.
- Stub core never responds, CORE_TIMEOUT=256 -> err=1 and FSM=IDLE within 256+2 cycles of core_init. Next accepted command clears err.
- abort 3 cycles into RUN of a nblocks=3 command -> blk_valid never asserts, no done, IDLE next cycle. A late core_blockready is ignored.
- ctr=0xFFFFFFFF, nblocks=2:
  - with CHACHA_CTR_WRAP_ERR_EN: one block delivered, then err=1, no done;
  - without it: second block has blk_ctr=0, then done.

Source files
------------

// File: rtl/chacha_pkg.sv
// rtl/chacha_pkg.sv - shared ChaCha20 types, sigma constants and scheduler state encoding
package chacha_pkg;

    typedef logic [31:0] word_t;
    typedef word_t [3:0][3:0] matrix_t;

    // "expand 32-byte k" as little-endian words
    localparam word_t CHACHA_C0 = 32'h61707865;
    localparam word_t CHACHA_C1 = 32'h3320646e;
    localparam word_t CHACHA_C2 = 32'h79622d32;
    localparam word_t CHACHA_C3 = 32'h6b206574;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        OUT  = 2'd3
    } sched_state_t;

endpackage

// File: rtl/chacha_state_build.sv
// rtl/chacha_state_build.sv - combinational key/nonce/counter to ChaCha20 initial state matrix
module chacha_state_build
    import chacha_pkg::*;
(
    input  logic [7:0][31:0]       key_i,
    input  logic [2:0][31:0]       nonce_i,
    input  logic [31:0]            ctr_i,
    output logic [3:0][3:0][31:0]  matrix_o
);

    always_comb begin
        matrix_o[0][0] = CHACHA_C0;
        matrix_o[0][1] = CHACHA_C1;
        matrix_o[0][2] = CHACHA_C2;
        matrix_o[0][3] = CHACHA_C3;
        for (int c = 0; c < 4; c++) begin
            matrix_o[1][c] = key_i[c];
            matrix_o[2][c] = key_i[c+4];
        end
        matrix_o[3][0] = ctr_i;
        matrix_o[3][1] = nonce_i[0];
        matrix_o[3][2] = nonce_i[1];
        matrix_o[3][3] = nonce_i[2];
    end

endmodule

// File: rtl/chacha_block_sched.sv
// rtl/chacha_block_sched.sv - sequences the ChaCha20 core over a run of keystream blocks
// Optional: CHACHA_CTR_WRAP_ERR_EN stops the run with err instead of wrapping the block counter.
module chacha_block_sched
    import chacha_pkg::*;
#(
    parameter int MAX_BLOCKS   = 16,
    parameter int CORE_TIMEOUT = 256
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               cmd_valid,
    output logic                               cmd_ready,
    input  logic [7:0][31:0]                   cmd_key,
    input  logic [2:0][31:0]                   cmd_nonce,
    input  logic [31:0]                        cmd_ctr,
    input  logic [$clog2(MAX_BLOCKS+1)-1:0]    cmd_nblocks,
    input  logic                               abort,
    output logic                               core_init,
    output logic [3:0][3:0][31:0]              core_matrix,
    input  logic                               core_blockready,
    input  logic [3:0][3:0][31:0]              core_result,
    output logic                               blk_valid,
    input  logic                               blk_ready,
    output logic [3:0][3:0][31:0]              blk_data,
    output logic [31:0]                        blk_ctr,
    output logic                               busy,
    output logic                               done,
    output logic                               err
);

    localparam int CW = $clog2(MAX_BLOCKS + 1);
    localparam int WW = $clog2(CORE_TIMEOUT + 1);

    sched_state_t      state_q;
    logic [7:0][31:0]  key_q;
    logic [2:0][31:0]  nonce_q;
    word_t             ctr_q;
    logic [CW-1:0]     left_q;
    logic [WW-1:0]     wd_q;

    logic              cmd_ready_q;
    logic              core_init_q;
    matrix_t           core_matrix_q;
    logic              blk_valid_q;
    matrix_t           blk_data_q;
    word_t             blk_ctr_q;
    logic              busy_q;
    logic              done_q;
    logic              err_q;

    // The matrix is built from the values that will apply in LOAD, so it can be
    // registered on the same edge that enters LOAD: fresh command fields from IDLE,
    // the latched key/nonce with the next counter from OUT.
    logic [7:0][31:0]  key_d;
    logic [2:0][31:0]  nonce_d;
    word_t             ctr_d;
    matrix_t           matrix_d;

    assign key_d   = (state_q == IDLE) ? cmd_key   : key_q;
    assign nonce_d = (state_q == IDLE) ? cmd_nonce : nonce_q;
    assign ctr_d   = (state_q == IDLE) ? cmd_ctr   : ctr_q + 32'd1;

    chacha_state_build u_state_build (
        .key_i    (key_d),
        .nonce_i  (nonce_d),
        .ctr_i    (ctr_d),
        .matrix_o (matrix_d)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            key_q         <= '0;
            nonce_q       <= '0;
            ctr_q         <= '0;
            left_q        <= '0;
            wd_q          <= '0;
            cmd_ready_q   <= 1'b1;
            core_init_q   <= 1'b0;
            core_matrix_q <= '0;
            blk_valid_q   <= 1'b0;
            blk_data_q    <= '0;
            blk_ctr_q     <= '0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            err_q         <= 1'b0;
        end else begin
            core_init_q <= 1'b0;
            done_q      <= 1'b0;
            if (abort && state_q != IDLE) begin
                state_q     <= IDLE;
                blk_valid_q <= 1'b0;
                cmd_ready_q <= 1'b1;
                busy_q      <= 1'b0;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (cmd_valid && cmd_ready_q) begin
                            key_q   <= cmd_key;
                            nonce_q <= cmd_nonce;
                            ctr_q   <= cmd_ctr;
                            left_q  <= cmd_nblocks;
                            err_q   <= 1'b0;
                            if (cmd_nblocks > CW'(MAX_BLOCKS)) begin
                                err_q <= 1'b1;
                            end else if (cmd_nblocks == '0) begin
                                done_q <= 1'b1;
                            end else begin
                                state_q       <= LOAD;
                                core_init_q   <= 1'b1;
                                core_matrix_q <= matrix_d;
                                cmd_ready_q   <= 1'b0;
                                busy_q        <= 1'b1;
                            end
                        end
                    end
                    LOAD: begin
                        wd_q    <= '0;
                        state_q <= RUN;
                    end
                    RUN: begin
                        if (core_blockready) begin
                            blk_data_q  <= core_result;
                            blk_ctr_q   <= ctr_q;
                            blk_valid_q <= 1'b1;
                            state_q     <= OUT;
                        end else if (wd_q == WW'(CORE_TIMEOUT - 1)) begin
                            err_q       <= 1'b1;
                            state_q     <= IDLE;
                            cmd_ready_q <= 1'b1;
                            busy_q      <= 1'b0;
                        end else begin
                            wd_q <= wd_q + WW'(1);
                        end
                    end
                    OUT: begin
                        if (blk_valid_q && blk_ready) begin
                            blk_valid_q <= 1'b0;
                            ctr_q       <= ctr_q + 32'd1;
                            left_q      <= left_q - CW'(1);
                            if (left_q == CW'(1)) begin
                                state_q     <= IDLE;
                                done_q      <= 1'b1;
                                cmd_ready_q <= 1'b1;
                                busy_q      <= 1'b0;
`ifdef CHACHA_CTR_WRAP_ERR_EN
                            end else if (ctr_q == 32'hFFFF_FFFF) begin
                                err_q       <= 1'b1;
                                state_q     <= IDLE;
                                cmd_ready_q <= 1'b1;
                                busy_q      <= 1'b0;
`endif
                            end else begin
                                state_q       <= LOAD;
                                core_init_q   <= 1'b1;
                                core_matrix_q <= matrix_d;
                            end
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign cmd_ready   = cmd_ready_q;
    assign core_init   = core_init_q;
    assign core_matrix = core_matrix_q;
    assign blk_valid   = blk_valid_q;
    assign blk_data    = blk_data_q;
    assign blk_ctr     = blk_ctr_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign err         = err_q;

endmodule

// File: tb/tb_chacha_block_sched.sv
// tb/tb_chacha_block_sched.sv - scoreboard bench for chacha_block_sched with a behavioural ChaCha20 core
module tb_chacha_block_sched;
    import chacha_pkg::*;

    logic                clk = 1'b0;
    logic                rst;
    logic                cmd_valid;
    logic                cmd_ready;
    logic [7:0][31:0]    cmd_key;
    logic [2:0][31:0]    cmd_nonce;
    logic [31:0]         cmd_ctr;
    logic [4:0]          cmd_nblocks;
    logic                abort;
    logic                core_init;
    matrix_t             core_matrix;
    logic                core_blockready;
    matrix_t             core_result;
    logic                blk_valid;
    logic                blk_ready;
    matrix_t             blk_data;
    logic [31:0]         blk_ctr;
    logic                busy;
    logic                done;
    logic                err;

    chacha_block_sched #(.MAX_BLOCKS(16), .CORE_TIMEOUT(256)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_key(cmd_key),
        .cmd_nonce(cmd_nonce), .cmd_ctr(cmd_ctr), .cmd_nblocks(cmd_nblocks),
        .abort(abort), .core_init(core_init), .core_matrix(core_matrix),
        .core_blockready(core_blockready), .core_result(core_result),
        .blk_valid(blk_valid), .blk_ready(blk_ready), .blk_data(blk_data),
        .blk_ctr(blk_ctr), .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        matrix_t data;
        word_t   ctr;
    } exp_t;

    exp_t    exp_q[$];
    int      n_tests = 0;
    int      n_fail = 0;
    int      done_cnt = 0;
    int      init_cnt = 0;
    bit      busy_seen = 0;
    bit      valid_seen = 0;
    matrix_t last_data = '0;
    int      core_lat = 10;
    bit      core_respond = 1;
    int      stall_len = 0;

    task automatic check(string name, logic [63:0] act, logic [63:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic check_m(string name, matrix_t act, matrix_t req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic word_t rotl(word_t x, int n);
        return (x << n) | (x >> (32 - n));
    endfunction

    // RFC 8439 block function on a 16-word state in natural order
    function automatic matrix_t chacha_core(matrix_t init);
        word_t   x[16];
        matrix_t r;
        int      qi[8][4] = '{'{0, 4, 8, 12}, '{1, 5, 9, 13}, '{2, 6, 10, 14}, '{3, 7, 11, 15},
                              '{0, 5, 10, 15}, '{1, 6, 11, 12}, '{2, 7, 8, 13}, '{3, 4, 9, 14}};
        for (int i = 0; i < 16; i++) x[i] = init[i/4][i%4];
        for (int dr = 0; dr < 10; dr++) begin
            for (int q = 0; q < 8; q++) begin
                word_t a, b, c, d;
                a = x[qi[q][0]]; b = x[qi[q][1]]; c = x[qi[q][2]]; d = x[qi[q][3]];
                a = a + b; d = rotl(d ^ a, 16);
                c = c + d; b = rotl(b ^ c, 12);
                a = a + b; d = rotl(d ^ a, 8);
                c = c + d; b = rotl(b ^ c, 7);
                x[qi[q][0]] = a; x[qi[q][1]] = b; x[qi[q][2]] = c; x[qi[q][3]] = d;
            end
        end
        for (int i = 0; i < 16; i++) r[i/4][i%4] = x[i] + init[i/4][i%4];
        return r;
    endfunction

    function automatic matrix_t init_state(word_t k[8], word_t n[3], word_t c);
        word_t   s[16];
        matrix_t m;
        s[0] = 32'h61707865; s[1] = 32'h3320646e; s[2] = 32'h79622d32; s[3] = 32'h6b206574;
        for (int i = 0; i < 8; i++) s[4+i] = k[i];
        s[12] = c; s[13] = n[0]; s[14] = n[1]; s[15] = n[2];
        for (int i = 0; i < 16; i++) m[i/4][i%4] = s[i];
        return m;
    endfunction

    // behavioural core: result appears core_lat cycles after an init pulse
    initial begin
        matrix_t stub_m;
        int      pend;
        stub_m = '0;
        pend = 0;
        core_blockready = 1'b0;
        core_result = '0;
        forever begin
            @(posedge clk); #1;
            core_blockready = 1'b0;
            for (int r = 0; r < 4; r++) for (int c = 0; c < 4; c++) core_result[r][c] = $urandom;
            if (core_init) begin
                init_cnt++;
                stub_m = core_matrix;
                pend = core_lat;
            end else if (pend > 0) begin
                pend--;
                if (pend == 0 && core_respond) begin
                    core_blockready = 1'b1;
                    core_result = chacha_core(stub_m);
                end
            end
        end
    end

    // downstream: stall each block stall_len cycles; ready is random while nothing is offered
    initial begin
        int hold;
        hold = 0;
        blk_ready = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (blk_valid) begin
                if (hold >= stall_len) begin
                    blk_ready = 1'b1;
                    hold = 0;
                end else begin
                    blk_ready = 1'b0;
                    hold++;
                end
            end else begin
                blk_ready = 1'($urandom_range(0, 1));
                hold = 0;
            end
        end
    end

    // monitor: every offered block must match the scoreboard head, popped on handshake
    initial begin
        forever begin
            @(negedge clk);
            if (done) done_cnt++;
            if (busy) busy_seen = 1;
            if (blk_valid) begin
                valid_seen = 1;
                if (exp_q.size() == 0) begin
                    check("unexpected_blk_valid", 64'(blk_valid), 64'(0));
                end else begin
                    check_m("blk_data", blk_data, exp_q[0].data);
                    check("blk_ctr", 64'(blk_ctr), 64'(exp_q[0].ctr));
                    if (blk_ready) begin
                        last_data = blk_data;
                        void'(exp_q.pop_front());
                    end
                end
            end
        end
    end

    initial begin
        #3000000;
        $display("FAIL global_timeout: actual=running required=finished");
        $fatal(1);
    end

    task automatic check_reset(string tag);
        check({tag, ".cmd_ready"}, 64'(cmd_ready), 64'(1));
        check({tag, ".core_init"}, 64'(core_init), 64'(0));
        check_m({tag, ".core_matrix"}, core_matrix, '0);
        check({tag, ".blk_valid"}, 64'(blk_valid), 64'(0));
        check_m({tag, ".blk_data"}, blk_data, '0);
        check({tag, ".blk_ctr"}, 64'(blk_ctr), 64'(0));
        check({tag, ".busy"}, 64'(busy), 64'(0));
        check({tag, ".done"}, 64'(done), 64'(0));
        check({tag, ".err"}, 64'(err), 64'(0));
    endtask

    task automatic issue(string tag, word_t k[8], word_t n[3], word_t c, int nb);
        int t = 0;
        while (!cmd_ready && t < 500) begin
            @(posedge clk); #1;
            t++;
        end
        if (t >= 500) check({tag, ".cmd_ready_wait"}, 64'(cmd_ready), 64'(1));
        for (int i = 0; i < 8; i++) cmd_key[i] = k[i];
        for (int i = 0; i < 3; i++) cmd_nonce[i] = n[i];
        cmd_ctr = c;
        cmd_nblocks = 5'(nb);
        cmd_valid = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_idle(string tag, int budget);
        int t = 0;
        while ((busy || blk_valid) && t < budget) begin
            @(posedge clk); #1;
            t++;
        end
        if (t >= budget) check({tag, ".idle_timeout"}, 64'(busy), 64'(0));
    endtask

    task automatic wait_init(string tag);
        int t = 0;
        while (init_cnt == 0 && t < 50) begin
            @(posedge clk); #1;
            t++;
        end
        if (t >= 50) check({tag, ".init_wait"}, 64'(init_cnt), 64'(1));
    endtask

    // reference: blocks ctr..ctr+nb-1; with the wrap guard the run stops after ctr 0xFFFFFFFF
    task automatic run_cmd(string tag, word_t k[8], word_t n[3], word_t c, int nb, int lat, int stall);
        int     ndel = nb;
        bit     e_done = 1;
        bit     e_err = 0;
        longint room = 64'h1_0000_0000 - longint'(c);
`ifdef CHACHA_CTR_WRAP_ERR_EN
        if (longint'(nb) > room) begin
            ndel = int'(room);
            e_done = 0;
            e_err = 1;
        end
`else
        if (room < 0) e_err = 1;
`endif
        core_lat = lat;
        core_respond = 1;
        stall_len = stall;
        for (int i = 0; i < ndel; i++) begin
            exp_t e;
            e.ctr = c + word_t'(i);
            e.data = chacha_core(init_state(k, n, e.ctr));
            exp_q.push_back(e);
        end
        done_cnt = 0;
        init_cnt = 0;
        issue(tag, k, n, c, nb);
        check({tag, ".err_cleared"}, 64'(err), 64'(0));
        wait_idle(tag, 3000);
        repeat (2) @(posedge clk);
        #1;
        check({tag, ".done_count"}, 64'(done_cnt), 64'(e_done));
        check({tag, ".err"}, 64'(err), 64'(e_err));
        check({tag, ".init_count"}, 64'(init_cnt), 64'(ndel));
        check({tag, ".blocks_left"}, 64'(exp_q.size()), 64'(0));
        check({tag, ".cmd_ready"}, 64'(cmd_ready), 64'(1));
        exp_q.delete();
    endtask

    initial begin
        word_t key[8];
        word_t nonce[3];
        int    t;

        rst = 1'b1;
        cmd_valid = 1'b0;
        cmd_key = '0;
        cmd_nonce = '0;
        cmd_ctr = '0;
        cmd_nblocks = '0;
        abort = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset("reset");
        rst = 1'b0;
        @(posedge clk); #1;

        // RFC 8439 2.3.2
        for (int i = 0; i < 8; i++) key[i] = {8'(4*i+3), 8'(4*i+2), 8'(4*i+1), 8'(4*i)};
        nonce[0] = 32'h09000000; nonce[1] = 32'h4a000000; nonce[2] = 32'h0;
        run_cmd("rfc", key, nonce, 32'd1, 1, 10, 0);
        check("rfc.word00", 64'(last_data[0][0]), 64'(32'he4e7f110));

        for (int i = 0; i < 8; i++) key[i] = $urandom;
        for (int i = 0; i < 3; i++) nonce[i] = $urandom;
        run_cmd("stall4", key, nonce, 32'd7, 4, 10, 5);

        // zero-length command
        done_cnt = 0; init_cnt = 0; busy_seen = 0;
        issue("nb0", key, nonce, 32'd3, 0);
        check("nb0.done_next", 64'(done), 64'(1));
        check("nb0.busy", 64'(busy), 64'(0));
        @(posedge clk); #1;
        check("nb0.done_one_cycle", 64'(done), 64'(0));
        repeat (3) @(posedge clk);
        #1;
        check("nb0.init_count", 64'(init_cnt), 64'(0));
        check("nb0.busy_seen", 64'(busy_seen), 64'(0));
        check("nb0.done_count", 64'(done_cnt), 64'(1));

        // silent core -> watchdog
        done_cnt = 0; init_cnt = 0;
        core_respond = 0;
        issue("tmo", key, nonce, 32'd0, 2);
        wait_init("tmo");
        t = 0;
        while (!err && t < 300) begin
            @(posedge clk); #1;
            t++;
        end
        check("tmo.err", 64'(err), 64'(1));
        check("tmo.not_late", 64'(t <= 258), 64'(1));
        check("tmo.not_early", 64'(t >= 256), 64'(1));
        check("tmo.busy", 64'(busy), 64'(0));
        check("tmo.cmd_ready", 64'(cmd_ready), 64'(1));
        repeat (2) @(posedge clk);
        #1;
        check("tmo.no_done", 64'(done_cnt), 64'(0));
        run_cmd("after_tmo", key, nonce, 32'd100, 1, 3, 1);

        // abort during RUN; the late core result must be ignored
        done_cnt = 0; init_cnt = 0; valid_seen = 0;
        core_respond = 1; core_lat = 10;
        issue("abort", key, nonce, 32'd20, 3);
        wait_init("abort");
        repeat (3) @(posedge clk);
        #1;
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        check("abort.busy", 64'(busy), 64'(0));
        check("abort.cmd_ready", 64'(cmd_ready), 64'(1));
        repeat (15) @(posedge clk);
        #1;
        check("abort.valid_seen", 64'(valid_seen), 64'(0));
        check("abort.no_done", 64'(done_cnt), 64'(0));
        check("abort.init_count", 64'(init_cnt), 64'(1));
        check("abort.err", 64'(err), 64'(0));

        run_cmd("wrap", key, nonce, 32'hFFFF_FFFF, 2, 5, 1);

        for (int it = 0; it < 12; it++) begin
            word_t c;
            for (int i = 0; i < 8; i++) key[i] = $urandom;
            for (int i = 0; i < 3; i++) nonce[i] = $urandom;
            c = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF - word_t'($urandom_range(0, 2)) : word_t'($urandom);
            run_cmd($sformatf("rnd%0d", it), key, nonce, c,
                    int'($urandom_range(1, 5)), int'($urandom_range(1, 20)), int'($urandom_range(0, 4)));
        end

        // reset in the middle of a run
        init_cnt = 0; valid_seen = 0;
        core_lat = 10;
        issue("midrst", key, nonce, 32'd55, 3);
        wait_init("midrst");
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        check_reset("midrst");
        rst = 1'b0;
        repeat (15) @(posedge clk);
        #1;
        check("midrst.valid_seen", 64'(valid_seen), 64'(0));
        check("midrst.init_count", 64'(init_cnt), 64'(1));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
